// File: rtl/seven_sensor_alarm_ctrl.sv
// Two-of-seven sensor fault vote: per-sensor sync + debounce, low-sensor count, and an
// arm/pending/alarm FSM with hold time. Optional SENSOR_MASK_EN adds a per-sensor mask port.
module seven_sensor_alarm_ctrl #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLD     = 8
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       X1,
    input  logic       X2,
    input  logic       X3,
    input  logic       X4,
    input  logic       X5,
    input  logic       X6,
    input  logic       X7,
`ifdef SENSOR_MASK_EN
    input  logic [6:0] mask,
`endif
    input  logic       arm,
    input  logic       ack,
    output logic       f,
    output logic [2:0] low_count,
    output logic [1:0] state,
    output logic       alarm
);

    localparam int unsigned DbW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

    typedef enum logic [1:0] {
        StDisarmed = 2'b00,
        StArmed    = 2'b01,
        StPending  = 2'b10,
        StAlarm    = 2'b11
    } state_e;

    logic [6:0]     x_raw;
    logic [6:0]     sync1_q, sync1_d;
    logic [6:0]     sync2_q, sync2_d;
    logic [6:0]     db_q, db_d;
    logic [DbW-1:0] db_cnt_q [7];
    logic [DbW-1:0] db_cnt_d [7];
    logic [6:0]     count_en;
    logic [2:0]     low_count_q, low_count_d;
    logic           f_q, f_d;
    state_e         state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic           alarm_q, alarm_d;

    assign x_raw = {X7, X6, X5, X4, X3, X2, X1};

`ifdef SENSOR_MASK_EN
    assign count_en = ~mask;
`else
    assign count_en = 7'h7f;
`endif

    always_comb begin
        sync1_d = x_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 7; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Count and vote both come from the same registered db snapshot.
    always_comb begin
        low_count_d = '0;
        for (int i = 0; i < 7; i++) begin
            if (!db_q[i] && count_en[i]) begin
                low_count_d = low_count_d + 3'd1;
            end
        end
        f_d = (low_count_d >= 3'd2);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StDisarmed: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (!arm) begin
                    state_d = StDisarmed;
                end else if (f_q) begin
                    state_d = StPending;
                    hold_d  = '0;
                end
            end
            StPending: begin
                if (!arm) begin
                    state_d = StDisarmed;
                end else if (!f_q) begin
                    state_d = StArmed;
                end else if (hold_q == HoldLast) begin
                    state_d = StAlarm;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StAlarm: begin
                // Ack with the vote still asserted is dropped, not remembered.
                if (ack && !f_q) state_d = StArmed;
            end
        endcase
        alarm_d = (state_d == StAlarm);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            db_q        <= '1;
            for (int i = 0; i < 7; i++) db_cnt_q[i] <= '0;
            low_count_q <= '0;
            f_q         <= 1'b0;
            state_q     <= StDisarmed;
            hold_q      <= '0;
            alarm_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            for (int i = 0; i < 7; i++) db_cnt_q[i] <= db_cnt_d[i];
            low_count_q <= low_count_d;
            f_q         <= f_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            alarm_q     <= alarm_d;
        end
    end

    assign f         = f_q;
    assign low_count = low_count_q;
    assign state     = state_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_seven_sensor_alarm_ctrl.sv
// Bench for seven_sensor_alarm_ctrl: directed scenarios plus randomized traffic, all checked
// against an edge-by-edge behavioural model. Define SENSOR_MASK_EN to cover the mask port.
module tb_seven_sensor_alarm_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [6:0] xin = 7'h7f;
    logic [6:0] mask_v = 7'h00;
    logic       arm = 1'b0;
    logic       ack = 1'b0;
    logic       f;
    logic [2:0] low_count;
    logic [1:0] state;
    logic       alarm;

    seven_sensor_alarm_ctrl #(
        .DEBOUNCE(DEB),
        .HOLD    (HOLD)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .X1       (xin[0]),
        .X2       (xin[1]),
        .X3       (xin[2]),
        .X4       (xin[3]),
        .X5       (xin[4]),
        .X6       (xin[5]),
        .X7       (xin[6]),
`ifdef SENSOR_MASK_EN
        .mask     (mask_v),
`endif
        .arm      (arm),
        .ack      (ack),
        .f        (f),
        .low_count(low_count),
        .state    (state),
        .alarm    (alarm)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Behavioural model: sensors as integer histories, pending timed by absolute edge number.
    int m_s1 [7];
    int m_s2 [7];
    int m_db [7];
    int m_run [7];
    int m_low = 0, m_f = 0, m_state = 0, m_alarm = 0;
    int m_edge = 0, m_pend_at = 0;
    int m_cnt, m_f_old;

    always @(posedge Clock) begin
        m_edge++;
        if (!Resetn) begin
            for (int i = 0; i < 7; i++) begin
                m_s1[i] = 1; m_s2[i] = 1; m_db[i] = 1; m_run[i] = 0;
            end
            m_low = 0; m_f = 0; m_state = 0; m_alarm = 0;
        end else begin
            m_f_old = m_f;
            m_cnt = 0;
            for (int i = 0; i < 7; i++) if (m_db[i] == 0 && !mask_v[i]) m_cnt++;
            for (int i = 0; i < 7; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_db[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(xin[i]);
            end
            m_low = m_cnt;
            m_f   = (m_cnt >= 2) ? 1 : 0;
            case (m_state)
                0: if (arm) m_state = 1;
                1: begin
                    if (!arm) m_state = 0;
                    else if (m_f_old == 1) begin
                        m_state = 2;
                        m_pend_at = m_edge;
                    end
                end
                2: begin
                    if (!arm) m_state = 0;
                    else if (m_f_old == 0) m_state = 1;
                    else if (m_edge - m_pend_at == HOLD) m_state = 3;
                end
                default: if (ack && m_f_old == 0) m_state = 1;
            endcase
            m_alarm = (m_state == 3) ? 1 : 0;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            check("model_low_count", low_count, m_low);
            check("model_f", f, m_f);
            check("model_state", state, m_state);
            check("model_alarm", alarm, m_alarm);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
        int k = 0;
        while (state !== s && k < lim) begin
            tick(1);
            k++;
        end
        check(tag, state, s);
    endtask

    task automatic wait_f_low(input int lim, input string tag);
        int k = 0;
        while (f !== 1'b0 && k < lim) begin
            tick(1);
            k++;
        end
        check(tag, f, 0);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        bit alarm_seen;

        // Reset state
        Resetn = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("rst_state", state, 0);
        check("rst_low", low_count, 0);
        check("rst_f", f, 0);
        check("rst_alarm", alarm, 0);
        Resetn = 1'b1;
        tick(3);
        check("idle_disarmed", state, 0);

        // Glitch rejection: X3, X5 low for 3 cycles
        arm = 1'b1;
        tick(3);
        xin[2] = 1'b0; xin[4] = 1'b0;
        tick(3);
        xin = 7'h7f;
        tick(12);
        check("glitch_low", low_count, 0);
        check("glitch_f", f, 0);
        check("glitch_state", state, 1);

        // Two-of-seven: X2, X6 dropped just after edge 0
        xin[1] = 1'b0; xin[5] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 6) check("two_low_e6", low_count, 0);
            if (k == 7) check("two_low_e7", low_count, 2);
            if (k == 7) check("two_state_e7", state, 1);
            if (k == 8) check("two_state_e8", state, 2);
            if (k == 15) check("two_alarm_e15", alarm, 0);
            if (k == 16) check("two_alarm_e16", alarm, 1);
        end
        xin = 7'h7f;
        wait_f_low(20, "two_release_f");
        pulse_ack();
        check("two_ack_armed", state, 1);

        // Single failure never alarms
        xin[3] = 1'b0;
        alarm_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (alarm) alarm_seen = 1'b1;
        end
        check("single_low", low_count, 1);
        check("single_f", f, 0);
        check("single_no_alarm", alarm_seen, 0);
        xin = 7'h7f;
        tick(10);

        // Ack while faulted is discarded
        xin[0] = 1'b0; xin[1] = 1'b0; xin[2] = 1'b0;
        wait_state(2'd3, 40, "faulted_reach_alarm");
        check("faulted_low", low_count, 3);
        pulse_ack();
        tick(1);
        check("faulted_ack_ignored", state, 3);
        xin = 7'h7f;
        wait_f_low(20, "faulted_release_f");
        tick(2);
        check("faulted_still_alarm", state, 3);
        pulse_ack();
        check("faulted_ack_armed", state, 1);

        // Disarm during PENDING
        xin[0] = 1'b0; xin[1] = 1'b0;
        wait_state(2'd2, 30, "disarm_reach_pending");
        arm = 1'b0;
        tick(1);
        check("disarm_pending", state, 0);
        xin = 7'h7f;
        arm = 1'b1;
        tick(12);

        // Reset mid-ALARM
        xin[0] = 1'b0; xin[1] = 1'b0;
        wait_state(2'd3, 40, "rstalarm_reach_alarm");
        Resetn = 1'b0; xin = 7'h7f; arm = 1'b0;
        tick(1);
        check("rstalarm_state", state, 0);
        check("rstalarm_alarm", alarm, 0);
        check("rstalarm_f", f, 0);
        check("rstalarm_low", low_count, 0);
        Resetn = 1'b1;
        tick(10);
        check("rstalarm_stays", state, 0);

`ifdef SENSOR_MASK_EN
        arm = 1'b1;
        mask_v = 7'b0000011;
        xin[0] = 1'b0; xin[1] = 1'b0;
        tick(12);
        check("mask_low", low_count, 0);
        check("mask_f", f, 0);
        xin[6] = 1'b0;
        tick(12);
        check("mask_x7_f", f, 0);
        check("mask_x7_low", low_count, 1);
        mask_v = 7'b0000000;
        tick(1);
        check("unmask_low", low_count, 3);
        xin = 7'h7f;
        tick(12);
        Resetn = 1'b0;
        tick(1);
        Resetn = 1'b1;
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            Resetn = ($urandom_range(0, 499) != 0);
            arm = ($urandom_range(0, 19) != 0);
            ack = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 7; i++) begin
                if (xin[i] == 1'b0) begin
                    if ($urandom_range(0, 14) == 0) xin[i] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    xin[i] = 1'b0;
                end
            end
`ifdef SENSOR_MASK_EN
            if ($urandom_range(0, 99) == 0) mask_v = 7'($urandom_range(0, 127));
`endif
            tick(1);
        end

        @(negedge Clock);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_sensor_alarm_ctrl.md
# seven_sensor_alarm_ctrl

Sequencing controller for the seven-sensor two-of-seven fault vote. It synchronizes and debounces seven raw sensor lines and counts the low (failed) sensors. It forms the registered vote "two or more sensors low" and runs an arm / pending / alarm / acknowledge state machine. The alarm latches only after the vote has persisted for a programmable hold time. The block sits between the raw sensor pins and the operator alarm indicator.

## Interface
Parameters:
- DEBOUNCE, 4: consecutive cycles a synchronized sensor must differ from its debounced value before the debounced value updates; legal range is 1 or more.
- HOLD, 8: cycles the vote must stay asserted in PENDING before ALARM; legal range is 1 or more.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-low reset.
- X1..X7  in  1 each  raw asynchronous sensor lines; 1 = healthy, 0 = failed.
- arm  in  1  level; 1 = monitoring enabled.
- ack  in  1  single-cycle or level operator acknowledge.
- f  out  1  registered vote: 1 when low_count is 2 or more.
- low_count  out  3  registered count of debounced sensors at 0, range 0..7.
- state  out  2  FSM state encoding: DISARMED=00, ARMED=01, PENDING=10, ALARM=11.
- alarm  out  1  1 exactly when state is ALARM.

## Operation
- Synchronizer: each Xi passes through a 2-flop synchronizer, giving si.
- Debounce, per sensor:
  - Each sensor has a debounced bit dbi and a counter.
  - If si equals dbi, the counter is cleared.
  - If si differs from dbi and the counter equals DEBOUNCE-1, dbi takes si and the counter clears.
  - Otherwise the counter increments.
- Count and vote: low_count is the registered popcount of the inverted db bits; f is registered as low_count ≥ 2, computed from the same db snapshot.
- FSM transitions:
  - DISARMED: arm=1 moves to ARMED.
  - ARMED: arm=0 moves to DISARMED. Otherwise f=1 moves to PENDING and clears hold_cnt.
  - PENDING: arm=0 moves to DISARMED, at highest priority. Otherwise f=0 moves to ARMED. Otherwise, if hold_cnt = HOLD-1, move to ALARM; if not, hold_cnt increments.
  - ALARM: latched, and arm is ignored. ack=1 with f=0 moves to ARMED. ack=1 with f=1 stays in ALARM, and the ack is discarded (not remembered).
- hold_cnt width is clog2(HOLD) with a minimum of 1; it never wraps, because it is only compared against HOLD-1.

## Timing
- Reset, while Resetn=0 at an edge:
  - Synchronizer flops and all dbi are set to 1.
  - Debounce counters and hold_cnt are set to 0.
  - low_count=0, f=0, state=DISARMED, alarm=0.
- Reset has priority over every event, including mid-debounce and mid-ALARM.
- Latency:
  - A held input change reaches dbi at edge 2+DEBOUNCE after the change.
  - low_count and f update one edge after that.
  - The ARMED→PENDING transition happens one edge after f rises.
  - ALARM is entered HOLD edges after PENDING entry.
  - With defaults, two sensors dropping before edge 0 give: db at edge 6, f at edge 7, PENDING at edge 8, alarm=1 at edge 16.
- Glitches: a pulse shorter than DEBOUNCE synchronized cycles never changes db.
- Simultaneous events:
  - arm=0 in the same cycle that PENDING would reach ALARM goes to DISARMED.
  - An f drop in the same cycle that the hold count would complete goes to ARMED.
- The outputs alarm and state are registered FSM outputs with no combinational path from any input.

## Configuration
- SENSOR_MASK_EN defined:
  - Adds the input port mask[6:0]; bit i-1 set excludes Xi.
  - A masked sensor is forced to count as healthy in low_count, regardless of dbi.
  - The mask is sampled combinationally into the count register, with the same one-edge latency.
- SENSOR_MASK_EN undefined: there is no mask port, and all seven sensors always count.

## Test plan
Bench defaults are DEBOUNCE=4 and HOLD=8.
- Reset mid-ALARM: assert Resetn=0 for one edge → state=00, alarm=0, f=0, low_count=0; X held at all 1 afterwards keeps state at DISARMED.
- Glitch rejection: arm=1, drop X3 and X5 for 3 cycles → low_count stays 0, f=0, state stays 01.
- Two-of-seven alarm: arm=1, hold X2=X6=0 → low_count=2 at edge 7, state=10 at edge 8, alarm=1 at edge 16. Then release X2 and X6 and pulse ack once f=0 → state=01.
- Single failure: hold X4=0 for 50 cycles → low_count=1, f=0, alarm never asserts.
- Ack while faulted: in ALARM with X1=X2=X3=0 (low_count=3), pulse ack → remains ALARM. Release the sensors, wait until f=0, pulse ack → ARMED. Set arm=0 during PENDING → DISARMED.
- SENSOR_MASK_EN defined: mask=0000011 with X1=X2=0 → low_count=0, f=0. Then add X7=0 → still f=0. Set mask=0 → low_count=3 one edge later.
